sys_bus_ctrl: RTL and testbench
===============================

// Module: sys_bus_ctrl
// PURPOSE
// - Parametrised CPU-side bus controller between the core's address/data pins and N memory-mapped devices.
// - Replaces the single hard-wired RAM hookup: decodes each CPU access to one device and applies per-device wait states.
// - Stalls the core via rdy and handles open-bus misses.
// - Optionally aggregates device interrupts onto the core irq pin.
// PARAMETERS
// - ADDR_W    16        CPU address width
// - DATA_W    8         data width
// - N_DEV     4         device channel count (1..8)
// - DEV_BASE  packed    N_DEV*ADDR_W base addresses; entry i in bits [i*ADDR_W +: ADDR_W]
// - DEV_MASK  packed    N_DEV*ADDR_W match masks; hit_i = ((addr & MASK_i) == BASE_i)
// - DEV_WAIT  packed    N_DEV*4 wait-state counts, 0..15 per device
// - OPEN_BUS  8'hFF     read data returned on a decode miss
// - CTRL_ADDR 16'hFFF0  IRQ control base address (used only with IRQ_AGG_EN)
// PORTS
// - clk        in   1              system clock, rising edge
// - clr        in   1              synchronous active-high reset
// - cpu_req    in   1              access request; must be held until cpu_done
// - cpu_rw     in   1              1 = read, 0 = write (core convention)
// - cpu_addr   in   ADDR_W         access address
// - cpu_wdata  in   DATA_W         write data
// - cpu_rdata  out  DATA_W         read data; valid while cpu_done = 1
// - cpu_done   out  1              one-cycle completion pulse
// - rdy        out  1              1 = idle / accepting; 0 = access in flight, core stalls
// - bus_err    out  1              sticky decode-miss flag; cleared only by clr
// - dev_sel    out  N_DEV          one-hot device select
// - dev_we     out  1              write strobe; qualified by dev_sel
// - dev_addr   out  ADDR_W         latched address
// - dev_wdata  out  DATA_W         latched write data
// - dev_rdata  in   N_DEV*DATA_W   per-device read data, packed
// - dev_irq    in   N_DEV          device interrupt lines, level-high (IRQ_AGG_EN only)
// - irq        out  1              aggregated interrupt to core, active-high (IRQ_AGG_EN only)
// BEHAVIOUR
// - All outputs registered.
// - Reset values:
//   - rdy = 1
//   - all of these = 0: cpu_done, cpu_rdata, bus_err, dev_sel, dev_we, dev_addr, dev_wdata, irq
// - FSM states: IDLE -> ACCESS -> DONE -> IDLE.
// - IDLE:
//   - cpu_req sampled at edge k latches addr, wdata, rw.
//   - Decode is priority: lowest matching index wins.
//   - On a hit: go to ACCESS; W = DEV_WAIT[hit].
//   - On a miss: go straight to DONE, set bus_err, return OPEN_BUS; writes are dropped.
// - ACCESS:
//   - dev_sel[hit], dev_addr and dev_wdata held; dev_we = ~rw.
//   - Lasts W+1 cycles (edges k+1 .. k+W+1); an internal down-counter is loaded with W.
//   - Read data is captured from dev_rdata[hit] on the final ACCESS edge.
// - DONE:
//   - cpu_done = 1 for one cycle; dev_sel = 0, dev_we = 0.
//   - Returns to IDLE; rdy = 1 again from the next cycle.
// - Latency: hit = W+2 cycles from request edge to cpu_done; miss = 1 cycle.
// - rdy = 0 from edge k+1 until cpu_done.
// - cpu_req while rdy = 0 is ignored.
// - cpu_req re-asserted in the DONE cycle is not accepted until IDLE.
// - Overlapping windows are legal; priority resolves them.
// - Wrap: addr 0xFFFF is treated as any other address; no carry or auto-increment.
// - clr mid-access: next edge forces IDLE and reset values, and drops dev_sel and dev_we.
//   - The in-flight write is abandoned.
//   - No cpu_done is issued.
// CONFIGURATION
// - Macro IRQ_AGG_EN is undefined by default.
// - With IRQ_AGG_EN defined:
//   - irq_en[N_DEV] register at CTRL_ADDR: read/write; reset 0.
//   - irq_pend[N_DEV] register at CTRL_ADDR+1:
//     - set on a dev_irq rising edge (edge detector per line);
//     - write-1-to-clear; reads return pend.
//   - A set edge and a W1C in the same cycle: set wins.
//   - irq = |(irq_pend & irq_en), registered (one cycle after pend/en change).
//   - Control accesses take precedence over device decode and take 0 waits.
// - Without IRQ_AGG_EN:
//   - no control registers; CTRL_ADDR decodes normally;
//   - dev_irq is ignored; irq is tied 0.
// STRUCTURE
// - Shared package bus_pkg:
//   - FSM state encoding (ST_IDLE, ST_ACCESS, ST_DONE);
//   - WAIT_W = 4;
//   - OPEN_BUS default;
//   - IRQ register offsets (IRQ_EN_OFS = 0, IRQ_PEND_OFS = 1).
// - Sub-module bus_addr_dec: combinational priority decoder
//   - inputs: addr, DEV_BASE/DEV_MASK;
//   - outputs: hit, idx.
// - Controller owns the FSM, wait counter, data latches and the IRQ block.
// TESTING
// 1. Read dev1, W=0, addr 0x2223 holding 0x01:
//    - dev_sel=0b0010 for 1 cycle;
//    - cpu_done at k+2 with cpu_rdata=0x01; rdy low 2 cycles.
// 2. Write 0x5A to dev2 with W=3:
//    - dev_we=1 and dev_sel=0b0100 for 4 cycles; dev_wdata=0x5A;
//    - cpu_done at k+5.
// 3. Read an unmapped address:
//    - cpu_done at k+1, cpu_rdata=0xFF, bus_err=1;
//    - bus_err stays 1 over later good accesses.
// 4. Overlap: dev0 and dev3 both match 0x8000 -> only dev_sel[0] is asserted.
// 5. clr asserted on the 2nd ACCESS cycle of a W=3 write:
//    - next cycle dev_sel=0, dev_we=0, rdy=1;
//    - no cpu_done pulse.
// 6. IRQ_AGG_EN:
//    - write 0x02 to CTRL_ADDR; pulse dev_irq[1] -> irq=1;
//    - read CTRL_ADDR+1 -> 0x02;
//    - W1C 0x02 -> irq=0;
//    - W1C in the same cycle as a new dev_irq[1] edge -> pend stays 1.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the CPU-side bus controller: FSM encoding, wait-state
// width, open-bus default and IRQ control register offsets.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int         WAIT_W        = 4;
    localparam logic [7:0] OPEN_BUS_DFLT = 8'hFF;
    localparam int         IRQ_EN_OFS    = 0;
    localparam int         IRQ_PEND_OFS  = 1;

endpackage

// File: rtl/bus_addr_dec.sv
// Combinational priority address decoder: the lowest-index window whose
// masked address equals its base wins.
module bus_addr_dec #(
    parameter int                       ADDR_W   = 16,
    parameter int                       N_DEV    = 4,
    parameter int                       IDX_W    = 2,
    parameter logic [N_DEV*ADDR_W-1:0]  DEV_BASE = '0,
    parameter logic [N_DEV*ADDR_W-1:0]  DEV_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    // Scanning from the top down lets the last (lowest) match overwrite the rest.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if ((addr & DEV_MASK[i*ADDR_W +: ADDR_W]) == DEV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sys_bus_ctrl.sv
// CPU bus controller: decodes each access to one of N_DEV devices, applies wait
// states, stalls the core via rdy. Optional IRQ aggregation under IRQ_AGG_EN.
module sys_bus_ctrl
    import bus_pkg::*;
#(
    parameter int                         ADDR_W    = 16,
    parameter int                         DATA_W    = 8,
    parameter int                         N_DEV     = 4,
    parameter logic [N_DEV*ADDR_W-1:0]    DEV_BASE  = {16'h8000, 16'h4000, 16'h2000, 16'h8000},
    parameter logic [N_DEV*ADDR_W-1:0]    DEV_MASK  = {16'hC000, 16'hF000, 16'hF000, 16'hF000},
    parameter logic [N_DEV*WAIT_W-1:0]    DEV_WAIT  = {4'd2, 4'd3, 4'd0, 4'd1},
    parameter logic [DATA_W-1:0]          OPEN_BUS  = DATA_W'(OPEN_BUS_DFLT),
    parameter logic [ADDR_W-1:0]          CTRL_ADDR = 16'hFFF0
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      cpu_req,
    input  logic                      cpu_rw,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_done,
    output logic                      rdy,
    output logic                      bus_err,
    output logic [N_DEV-1:0]          dev_sel,
    output logic                      dev_we,
    output logic [ADDR_W-1:0]         dev_addr,
    output logic [DATA_W-1:0]         dev_wdata,
    input  logic [N_DEV*DATA_W-1:0]   dev_rdata,
    input  logic [N_DEV-1:0]          dev_irq,
    output logic                      irq
);

    localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d, dec_idx;
    logic                rw_q, rw_d, dec_hit;
    logic                rdy_d, done_d, err_d, we_d;
    logic [DATA_W-1:0]   rdata_d, wdata_d;
    logic [N_DEV-1:0]    sel_d;
    logic [ADDR_W-1:0]   addr_d;

    bus_addr_dec #(
        .ADDR_W   (ADDR_W),
        .N_DEV    (N_DEV),
        .IDX_W    (IDX_W),
        .DEV_BASE (DEV_BASE),
        .DEV_MASK (DEV_MASK)
    ) u_dec (
        .addr (cpu_addr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

`ifdef IRQ_AGG_EN
    localparam logic [ADDR_W-1:0] EN_ADDR   = CTRL_ADDR + ADDR_W'(IRQ_EN_OFS);
    localparam logic [ADDR_W-1:0] PEND_ADDR = CTRL_ADDR + ADDR_W'(IRQ_PEND_OFS);

    logic             ctrl_q, ctrl_d, creg_q, creg_d, ctrl_hit, ctrl_reg;
    logic [N_DEV-1:0] irq_en, irq_pend, irq_prev, en_d, w1c;

    assign ctrl_hit = (cpu_addr == EN_ADDR) || (cpu_addr == PEND_ADDR);
    assign ctrl_reg = (cpu_addr == PEND_ADDR);
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        rdy_d   = rdy;
        done_d  = 1'b0;
        rdata_d = cpu_rdata;
        err_d   = bus_err;
        sel_d   = dev_sel;
        we_d    = dev_we;
        addr_d  = dev_addr;
        wdata_d = dev_wdata;
`ifdef IRQ_AGG_EN
        ctrl_d  = ctrl_q;
        creg_d  = creg_q;
        en_d    = irq_en;
        w1c     = '0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    rw_d    = cpu_rw;
                    idx_d   = dec_idx;
                    rdy_d   = 1'b0;
`ifdef IRQ_AGG_EN
                    ctrl_d  = ctrl_hit;
                    creg_d  = ctrl_reg;
                    if (ctrl_hit) begin
                        state_d = ST_ACCESS;
                        cnt_d   = '0;
                    end else
`endif
                    if (dec_hit) begin
                        state_d = ST_ACCESS;
                        cnt_d   = DEV_WAIT[dec_idx*WAIT_W +: WAIT_W];
                        sel_d   = N_DEV'(1) << dec_idx;
                        we_d    = ~cpu_rw;
                    end else begin
                        // Decode miss: writes are dropped, reads see the open bus.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = OPEN_BUS;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    if (rw_q) rdata_d = dev_rdata[idx_q*DATA_W +: DATA_W];
`ifdef IRQ_AGG_EN
                    if (ctrl_q) begin
                        if (rw_q) begin
                            rdata_d = '0;
                            rdata_d[N_DEV-1:0] = creg_q ? irq_pend : irq_en;
                        end else if (creg_q) begin
                            w1c = dev_wdata[N_DEV-1:0];
                        end else begin
                            en_d = dev_wdata[N_DEV-1:0];
                        end
                    end
`endif
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                rdy_d   = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (clr) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            rw_q      <= 1'b0;
            rdy       <= 1'b1;
            cpu_done  <= 1'b0;
            cpu_rdata <= '0;
            bus_err   <= 1'b0;
            dev_sel   <= '0;
            dev_we    <= 1'b0;
            dev_addr  <= '0;
            dev_wdata <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rw_q      <= rw_d;
            rdy       <= rdy_d;
            cpu_done  <= done_d;
            cpu_rdata <= rdata_d;
            bus_err   <= err_d;
            dev_sel   <= sel_d;
            dev_we    <= we_d;
            dev_addr  <= addr_d;
            dev_wdata <= wdata_d;
        end
    end

`ifdef IRQ_AGG_EN
    // A rising edge landing with a W1C of the same bit keeps the bit set.
    always_ff @(posedge clk) begin
        if (clr) begin
            ctrl_q   <= 1'b0;
            creg_q   <= 1'b0;
            irq_en   <= '0;
            irq_pend <= '0;
            irq_prev <= '0;
            irq      <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            creg_q   <= creg_d;
            irq_en   <= en_d;
            irq_pend <= (irq_pend & ~w1c) | (dev_irq & ~irq_prev);
            irq_prev <= dev_irq;
            irq      <= |(irq_pend & irq_en);
        end
    end
`else
    logic unused_irq_cfg;
    assign unused_irq_cfg = ^{dev_irq, CTRL_ADDR};
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// Self-checking bench for sys_bus_ctrl: directed scenarios plus randomized
// accesses checked against a decode/latency model of the device map.
module tb_sys_bus_ctrl;

    logic        clk = 1'b0;
    logic        clr, cpu_req, cpu_rw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_done, rdy, bus_err;
    logic [3:0]  dev_sel;
    logic        dev_we;
    logic [15:0] dev_addr;
    logic [7:0]  dev_wdata;
    logic [31:0] dev_rdata;
    logic [3:0]  dev_irq;
    logic        irq;

    int total = 0;
    int bad   = 0;
    logic err_exp = 1'b0;

    // Device map of the default build: dev0 0x8xxx (W1), dev1 0x2xxx (W0),
    // dev2 0x4xxx (W3), dev3 0x8000-0xBFFF (W2).
    logic [15:0] m_base [4] = '{16'h8000, 16'h2000, 16'h4000, 16'h8000};
    logic [15:0] m_mask [4] = '{16'hF000, 16'hF000, 16'hF000, 16'hC000};
    int          m_wait [4] = '{1, 0, 3, 2};

    always #5 clk = ~clk;

    sys_bus_ctrl dut (
        .clk       (clk),
        .clr       (clr),
        .cpu_req   (cpu_req),
        .cpu_rw    (cpu_rw),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .rdy       (rdy),
        .bus_err   (bus_err),
        .dev_sel   (dev_sel),
        .dev_we    (dev_we),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_rdata (dev_rdata),
        .dev_irq   (dev_irq),
        .irq       (irq)
    );

    function automatic void model_decode(input logic [15:0] a, output bit hit, output int idx);
        hit = 0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            if (!hit && ((a & m_mask[i]) == m_base[i])) begin
                hit = 1;
                idx = i;
            end
        end
    endfunction

    // One CPU access. The addressed device's read data changes every cycle
    // (rv + cycle index) so only the final ACCESS edge yields rv + W.
    task automatic do_access(input logic rw, input logic [15:0] a, input logic [7:0] wd,
                             input logic [7:0] rv, input logic [7:0] ctrl_rd,
                             input bit keep_req, input string tag);
        bit         hit, is_ctrl;
        int         idx, w, lat, sel_cnt, low_cnt, done_at;
        logic [3:0] exp_sel;
        logic [7:0] exp_rd;
        is_ctrl = 0;
`ifdef IRQ_AGG_EN
        if (a == 16'hFFF0 || a == 16'hFFF1) is_ctrl = 1;
`endif
        model_decode(a, hit, idx);
        if (is_ctrl) begin
            hit = 1;
            w   = 0;
        end else begin
            w = hit ? m_wait[idx] : 0;
        end
        lat     = hit ? w + 2 : 1;
        exp_sel = (hit && !is_ctrl) ? 4'(1 << idx) : 4'b0000;
        exp_rd  = !hit ? 8'hFF : (is_ctrl ? ctrl_rd : 8'(rv + w));
        if (!hit) err_exp = 1'b1;

        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_rw    = rw;
        cpu_addr  = a;
        cpu_wdata = wd;
        dev_rdata = $urandom;
        dev_rdata[idx*8 +: 8] = 8'(rv - 1);
        sel_cnt = 0;
        low_cnt = 0;
        done_at = -1;
        @(posedge clk);
        for (int c = 0; c < 24; c++) begin
            #1;
            if (dev_sel !== 4'b0000) begin
                sel_cnt++;
                total++;
                if (dev_sel !== exp_sel) begin
                    bad++;
                    $display("FAIL %s dev_sel got=%b want=%b", tag, dev_sel, exp_sel);
                end
                total++;
                if (dev_we !== ~rw) begin
                    bad++;
                    $display("FAIL %s dev_we got=%b want=%b", tag, dev_we, ~rw);
                end
                total++;
                if (dev_addr !== a) begin
                    bad++;
                    $display("FAIL %s dev_addr got=%h want=%h", tag, dev_addr, a);
                end
                if (!rw) begin
                    total++;
                    if (dev_wdata !== wd) begin
                        bad++;
                        $display("FAIL %s dev_wdata got=%h want=%h", tag, dev_wdata, wd);
                    end
                end
            end
            if (rdy === 1'b0) low_cnt++;
            if (cpu_done === 1'b1) begin
                done_at = c;
                if (rw) begin
                    total++;
                    if (cpu_rdata !== exp_rd) begin
                        bad++;
                        $display("FAIL %s cpu_rdata got=%h want=%h", tag, cpu_rdata, exp_rd);
                    end
                end
                total++;
                if (bus_err !== err_exp) begin
                    bad++;
                    $display("FAIL %s bus_err got=%b want=%b", tag, bus_err, err_exp);
                end
            end
            @(negedge clk);
            dev_rdata[idx*8 +: 8] = 8'(rv + c);
            if (done_at >= 0) begin
                if (!keep_req) cpu_req = 1'b0;
                break;
            end
            @(posedge clk);
        end
        if (done_at < 0) cpu_req = 1'b0;
        total++;
        if (done_at != lat - 1) begin
            bad++;
            $display("FAIL %s done_cycle got=%0d want=%0d", tag, done_at + 1, lat);
        end
        total++;
        if (sel_cnt != ((exp_sel != 0) ? w + 1 : 0)) begin
            bad++;
            $display("FAIL %s sel_cycles got=%0d want=%0d", tag, sel_cnt, (exp_sel != 0) ? w + 1 : 0);
        end
        total++;
        if (low_cnt != lat) begin
            bad++;
            $display("FAIL %s rdy_low_cycles got=%0d want=%0d", tag, low_cnt, lat);
        end
        @(posedge clk);
        #1;
        total++;
        if (rdy !== 1'b1 || cpu_done !== 1'b0 || dev_sel !== 4'b0000) begin
            bad++;
            $display("FAIL %s after_done rdy/done/sel got=%b/%b/%b want=1/0/0", tag, rdy, cpu_done, dev_sel);
        end
    endtask

    task automatic test_reset();
        clr       = 1'b1;
        cpu_req   = 1'b1;
        cpu_rw    = 1'b0;
        cpu_addr  = 16'h2000;
        cpu_wdata = 8'h3C;
        dev_rdata = '0;
        dev_irq   = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (rdy !== 1'b1 || cpu_done !== 1'b0 || cpu_rdata !== 8'h00 || bus_err !== 1'b0) begin
            bad++;
            $display("FAIL reset rdy/done/rdata/err got=%b/%b/%h/%b want=1/0/00/0", rdy, cpu_done, cpu_rdata, bus_err);
        end
        total++;
        if (dev_sel !== 4'b0 || dev_we !== 1'b0 || dev_addr !== 16'h0 || dev_wdata !== 8'h0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL reset sel/we/addr/wdata/irq got=%b/%b/%h/%h/%b want=0000/0/0000/00/0",
                     dev_sel, dev_we, dev_addr, dev_wdata, irq);
        end
        @(negedge clk);
        clr     = 1'b0;
        cpu_req = 1'b0;
    endtask

    task automatic test_read_w0();
        do_access(1'b1, 16'h2223, 8'h00, 8'h01, 8'h00, 0, "read_dev1_w0");
    endtask

    task automatic test_write_w3();
        do_access(1'b0, 16'h4321, 8'h5A, 8'h00, 8'h00, 0, "write_dev2_w3");
    endtask

    task automatic test_miss();
        do_access(1'b1, 16'h0100, 8'h00, 8'h11, 8'h00, 0, "miss_read");
        do_access(1'b0, 16'h6000, 8'h99, 8'h00, 8'h00, 0, "miss_write");
        do_access(1'b1, 16'h2FFE, 8'h00, 8'hC3, 8'h00, 0, "err_sticky");
    endtask

    task automatic test_overlap();
        do_access(1'b1, 16'h8000, 8'h00, 8'h80, 8'h00, 0, "overlap_8000");
        do_access(1'b1, 16'h9000, 8'h00, 8'h90, 8'h00, 0, "dev3_9000");
    endtask

    task automatic test_boundaries();
        do_access(1'b1, 16'hFFFF, 8'h00, 8'h10, 8'h00, 0, "wrap_ffff");
        do_access(1'b1, 16'h8FFF, 8'h00, 8'h20, 8'h00, 0, "dev0_top");
        do_access(1'b0, 16'hBFFF, 8'hE7, 8'h00, 8'h00, 0, "dev3_top");
        do_access(1'b1, 16'hC000, 8'h00, 8'h30, 8'h00, 0, "above_dev3");
        do_access(1'b1, 16'h1FFF, 8'h00, 8'h40, 8'h00, 0, "below_dev1");
        do_access(1'b1, 16'h2000, 8'h00, 8'h50, 8'h00, 0, "dev1_base");
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 16'h2010, 8'h00, 8'h33, 8'h00, 1, "b2b_a");
        do_access(1'b0, 16'h4020, 8'h77, 8'h00, 8'h00, 1, "b2b_b");
        do_access(1'b1, 16'h8800, 8'h00, 8'h44, 8'h00, 0, "b2b_c");
    endtask

    task automatic test_random();
        logic [15:0] a;
        int          r, d;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 5);
            if (r < 4) begin
                d = r;
                a = m_base[d] | (16'($urandom) & ~m_mask[d]);
            end else begin
                a = 16'($urandom);
            end
            if (a == 16'hFFF0 || a == 16'hFFF1) a = 16'hFFF2;
            do_access(1'($urandom), a, 8'($urandom), 8'($urandom), 8'h00, 1'($urandom), "random");
        end
    endtask

`ifdef IRQ_AGG_EN
    task automatic test_irq();
        do_access(1'b0, 16'hFFF0, 8'h02, 8'h00, 8'h00, 0, "irq_en_wr");
        do_access(1'b1, 16'hFFF0, 8'h00, 8'h00, 8'h02, 0, "irq_en_rd");
        @(negedge clk);
        dev_irq = 4'b0010;
        @(negedge clk);
        dev_irq = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_assert got=%b want=1", irq);
        end
        do_access(1'b1, 16'hFFF1, 8'h00, 8'h00, 8'h02, 0, "irq_pend_rd");
        do_access(1'b0, 16'hFFF1, 8'h02, 8'h00, 8'h00, 0, "irq_w1c");
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_clear got=%b want=0", irq);
        end
        do_access(1'b1, 16'hFFF1, 8'h00, 8'h00, 8'h00, 0, "irq_pend_zero");
        @(negedge clk);
        dev_irq = 4'b0010;
        @(negedge clk);
        dev_irq = 4'b0000;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_rw    = 1'b0;
        cpu_addr  = 16'hFFF1;
        cpu_wdata = 8'h02;
        @(posedge clk);
        @(negedge clk);
        dev_irq = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        dev_irq = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_set_wins got=%b want=1", irq);
        end
        do_access(1'b1, 16'hFFF1, 8'h00, 8'h00, 8'h02, 0, "irq_pend_kept");
        do_access(1'b0, 16'hFFF0, 8'h00, 8'h00, 8'h00, 0, "irq_en_off");
        @(posedge clk);
        #1;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_masked got=%b want=0", irq);
        end
    endtask
`else
    task automatic test_irq();
        int nz = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dev_irq = 4'($urandom);
            @(posedge clk);
            #1;
            if (irq !== 1'b0) nz++;
        end
        dev_irq = 4'b0000;
        total++;
        if (nz != 0) begin
            bad++;
            $display("FAIL irq_tied_off got=%0d nonzero cycles want=0", nz);
        end
        do_access(1'b1, 16'hFFF0, 8'h00, 8'h00, 8'h00, 0, "ctrl_addr_miss");
    endtask
`endif

    task automatic test_clr_mid();
        int dones = 0;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_rw    = 1'b0;
        cpu_addr  = 16'h4100;
        cpu_wdata = 8'hA5;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (dev_sel !== 4'b0000 || dev_we !== 1'b0 || rdy !== 1'b1 || bus_err !== 1'b0) begin
            bad++;
            $display("FAIL clr_mid sel/we/rdy/err got=%b/%b/%b/%b want=0000/0/1/0", dev_sel, dev_we, rdy, bus_err);
        end
        if (cpu_done !== 1'b0) dones++;
        @(negedge clk);
        clr     = 1'b0;
        cpu_req = 1'b0;
        err_exp = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (cpu_done !== 1'b0) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL clr_no_done got=%0d pulses want=0", dones);
        end
        do_access(1'b1, 16'h2400, 8'h00, 8'h66, 8'h00, 0, "after_clr");
    endtask

    initial begin
        test_reset();
        test_read_w0();
        test_write_w3();
        test_miss();
        test_overlap();
        test_boundaries();
        test_back_to_back();
        test_random();
        test_irq();
        test_clr_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
